// File: rtl/sram_pkg.sv
// Shared definitions for the async-SRAM PHY controller: FSM states, wait-counter width,
// and the inactive (reset) levels of the active-low pin strobes.
package sram_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_t;

    localparam logic       STROBE_IDLE = 1'b1;
    localparam logic [3:0] BE_N_IDLE   = 4'hF;

endpackage

// File: rtl/sram_phy_ctrl.sv
// Responder for one RAM bank: turns a word request into a timed async-SRAM cycle.
// Optional SRAM_PERF_CNT_EN adds rd_cnt/wr_cnt completion counters.
module sram_phy_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_en,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              wr_done,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_dq_i,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
`ifdef SRAM_PERF_CNT_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
`endif
);

    localparam logic [WAIT_CNT_W-1:0] RD_CNT_INIT = WAIT_CNT_W'(RD_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WR_CNT_INIT = WAIT_CNT_W'(WR_WAIT);

    state_t                  state, state_nx;
    logic [WAIT_CNT_W-1:0]   cnt, cnt_nx;
    logic                    accept;
    logic                    rd_fire;
    logic                    wr_fire;
    logic                    unused_addr_bits;

    // Bank decode and byte offset live upstream.
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_en & req_ready;
    assign rd_fire   = (state == ST_RD) && (cnt == '0);
    assign wr_fire   = (state == ST_WR_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        state_nx = ST_WR_SETUP;
                    end else begin
                        state_nx = ST_RD;
                        cnt_nx   = RD_CNT_INIT;
                    end
                end
            end
            ST_RD: begin
                if (cnt == '0) state_nx = ST_IDLE;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_WR_SETUP: begin
                state_nx = ST_WR_PULSE;
                cnt_nx   = WR_CNT_INIT;
            end
            ST_WR_PULSE: begin
                if (cnt == '0) state_nx = ST_WR_HOLD;
                else           cnt_nx   = cnt - 1'b1;
            end
            ST_WR_HOLD: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Pins are registered from the next state so each strobe changes on one clean edge;
    // ce_n and dq_oe release together on the edge that returns to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_ce_n  <= STROBE_IDLE;
            sram_oe_n  <= STROBE_IDLE;
            sram_we_n  <= STROBE_IDLE;
            sram_be_n  <= BE_N_IDLE;
            sram_dq_oe <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b0;
            wr_done    <= 1'b0;
        end else begin
            rsp_valid <= rd_fire;
            wr_done   <= wr_fire;
            if (rd_fire) rsp_rdata <= sram_dq_i;
            sram_we_n <= (state_nx != ST_WR_PULSE);
            if (accept) begin
                sram_addr  <= req_addr[ADDR_W+1:2];
                sram_dq_o  <= req_wdata;
                sram_ce_n  <= 1'b0;
                sram_oe_n  <= req_we;
                sram_dq_oe <= req_we;
                sram_be_n  <= req_we ? ~req_be : '0;
            end else if (state_nx == ST_IDLE) begin
                sram_ce_n  <= STROBE_IDLE;
                sram_oe_n  <= STROBE_IDLE;
                sram_dq_oe <= 1'b0;
                sram_be_n  <= BE_N_IDLE;
            end
        end
    end

`ifdef SRAM_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_fire) rd_cnt <= rd_cnt + 32'd1;
            if (wr_fire) wr_cnt <= wr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_phy_ctrl.sv
// Scoreboard bench for sram_phy_ctrl: stimulus pushes expected completions, a monitor
// pops them on rsp_valid/wr_done and checks data and latency; pin timing checked inline.
module tb_sram_phy_ctrl;

    localparam int ADDR_W  = 20;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_en, req_we;
    logic [3:0]        req_be;
    logic [31:0]       req_addr, req_wdata;
    logic              req_ready, rsp_valid, wr_done;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dq_i, sram_dq_o;
    logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]        sram_be_n;
`ifdef SRAM_PERF_CNT_EN
    logic [31:0]       rd_cnt, wr_cnt;
`endif

    sram_phy_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_en(req_en), .req_we(req_we), .req_be(req_be),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
`ifdef SRAM_PERF_CNT_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the oldest expectation, in data and in cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("oe_dq_overlap", {31'b0, (!sram_oe_n && sram_dq_oe)}, 32'd0);
            if (rsp_valid || wr_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_kind", {31'b0, rsp_valid}, {31'b0, e.is_rd});
                    if (e.is_rd) chk("rsp_rdata", rsp_rdata, e.data);
                    chk("rsp_latency", cyc, e.due);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting posedge with req_en still high.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd_exp, input bit push,
                         output int acc);
        exp_t e;
        int   n = 0;
        req_en = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        acc = cyc;
        if (push) begin
            e.is_rd = !we;
            e.data  = rd_exp;
            e.due   = we ? acc + WR_WAIT + 3 : acc + RD_WAIT + 1;
            sb.push_back(e);
            if (we) exp_wr++;
            else    exp_rd++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int acc, acc2, lows, oe_cyc, n;
        reset = 1'b1; req_en = 1'b0; req_we = 1'b0; req_be = '0;
        req_addr = '0; req_wdata = '0; sram_dq_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_ce_n",   {31'b0, sram_ce_n},  32'd1);
        chk("rst_oe_n",   {31'b0, sram_oe_n},  32'd1);
        chk("rst_we_n",   {31'b0, sram_we_n},  32'd1);
        chk("rst_be_n",   {28'b0, sram_be_n},  32'hF);
        chk("rst_dq_oe",  {31'b0, sram_dq_oe}, 32'd0);
        chk("rst_addr",   {12'b0, sram_addr},  32'd0);
        chk("rst_dq_o",   sram_dq_o,           32'd0);
        chk("rst_rdata",  rsp_rdata,           32'd0);
        chk("rst_ready",  {31'b0, req_ready},  32'd1);

        // Basic read: oe_n low for RD_WAIT+1 cycles
        sram_dq_i = 32'h1234_5678;
        issue(1'b0, 4'h0, 32'h8000_0010, 32'h0, 32'h1234_5678, 1'b1, acc);
        req_en = 1'b0;
        chk("rd_addr",  {12'b0, sram_addr},  32'h4);
        chk("rd_ce_n",  {31'b0, sram_ce_n},  32'd0);
        chk("rd_be_n",  {28'b0, sram_be_n},  32'h0);
        chk("rd_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("rd_ready", {31'b0, req_ready},  32'd0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (sram_oe_n) break;
            lows++;
            @(negedge clk);
        end
        chk("rd_oe_low_cycles", lows, 32'd2);

        // Basic write: we_n low 2 cycles, dq_oe high 4 cycles
        issue(1'b1, 4'b0011, 32'h8000_0020, 32'hAABB_CCDD, 32'h0, 1'b1, acc);
        req_en = 1'b0;
        chk("wr_be_n",  {28'b0, sram_be_n},  32'hC);
        chk("wr_dq_o",  sram_dq_o,           32'hAABB_CCDD);
        chk("wr_addr",  {12'b0, sram_addr},  32'h8);
        chk("wr_setup_we_n", {31'b0, sram_we_n}, 32'd1);
        lows = 0; oe_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!sram_dq_oe) break;
            oe_cyc++;
            if (!sram_we_n) lows++;
            @(negedge clk);
        end
        chk("wr_we_low_cycles", lows,   32'd2);
        chk("wr_dq_oe_cycles",  oe_cyc, 32'd4);
        chk("wr_ce_n_release",  {31'b0, sram_ce_n}, 32'd1);

        // Back-to-back read then write with req_en held
        sram_dq_i = 32'hCAFE_F00D;
        issue(1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 1'b1, acc);
        chk("b2b_rd_addr", {12'b0, sram_addr}, 32'h40);
        issue(1'b1, 4'hF, 32'h0000_0200, 32'h0F0F_0F0F, 32'h0, 1'b1, acc2);
        req_en = 1'b0;
        chk("b2b_gap", acc2 - acc, 32'd3);
        chk("b2b_wr_addr", {12'b0, sram_addr}, 32'h80);
        chk("b2b_wr_dq_o", sram_dq_o, 32'h0F0F_0F0F);
        wait_idle();

        // Request toggled during WR_PULSE must be ignored
        issue(1'b1, 4'hF, 32'h0000_0300, 32'h1111_2222, 32'h0, 1'b1, acc);
        req_en = 1'b0;
        n = 0;
        while (sram_we_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_reached", {31'b0, sram_we_n}, 32'd0);
        req_en = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0400;
        chk("pulse_ready0", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("pulse_ready1", {31'b0, req_ready}, 32'd0);
        req_en = 1'b0;
        wait_idle();
        chk("toggle_not_latched", {12'b0, sram_addr}, 32'hC0);

        // Write with no byte lanes: full timing, lanes stay off
        issue(1'b1, 4'h0, 32'h0000_0500, 32'hDEAD_BEEF, 32'h0, 1'b1, acc);
        req_en = 1'b0;
        chk("be0_be_n",  {28'b0, sram_be_n},  32'hF);
        chk("be0_dq_oe", {31'b0, sram_dq_oe}, 32'd1);
        wait_idle();

        // Upper address bits ignored
        sram_dq_i = 32'h5A5A_5A5A;
        issue(1'b0, 4'h0, 32'hFFC0_0004, 32'h0, 32'h5A5A_5A5A, 1'b1, acc);
        req_en = 1'b0;
        chk("hi_addr", {12'b0, sram_addr}, 32'h1);
        wait_idle();
        repeat (2) @(negedge clk);

`ifdef SRAM_PERF_CNT_EN
        chk("perf_rd_cnt", rd_cnt, exp_rd);
        chk("perf_wr_cnt", wr_cnt, exp_wr);
`endif

        // Async reset in the middle of the we_n pulse
        issue(1'b1, 4'hF, 32'h0000_0600, 32'h7777_8888, 32'h0, 1'b0, acc);
        req_en = 1'b0;
        n = 0;
        while (sram_we_n && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_we_n",  {31'b0, sram_we_n},  32'd1);
        chk("arst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("arst_ce_n",  {31'b0, sram_ce_n},  32'd1);
        chk("arst_be_n",  {28'b0, sram_be_n},  32'hF);
        @(negedge clk);
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0;
        chk("arst_ready",   {31'b0, req_ready}, 32'd1);
        chk("arst_wr_done", {31'b0, wr_done},   32'd0);
`ifdef SRAM_PERF_CNT_EN
        chk("perf_rd_clr", rd_cnt, 32'd0);
        chk("perf_wr_clr", wr_cnt, 32'd0);
`endif

        // Normal read after reset release
        sram_dq_i = 32'h0BAD_F00D;
        issue(1'b0, 4'h0, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, 1'b1, acc);
        req_en = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
`ifdef SRAM_PERF_CNT_EN
        chk("perf_rd_after", rd_cnt, exp_rd);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
